// File: rtl/stopwatch_time_keeper_if.sv
// rtl/stopwatch_time_keeper_if.sv - control pulses and BCD display bundle for the stopwatch
// Macro STOPWATCH_LAP_HOLD_EN adds the lap / lap_active signals.
interface stopwatch_time_keeper_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       wrap;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap;
  logic       lap_active;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens, running, wrap, lap_active
  );
  modport slave (
    input  tick_in, start_stop, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens, running, wrap, lap_active
  );
`else
  modport master (
    output tick_in, start_stop, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
  );
  modport slave (
    input  tick_in, start_stop, clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, wrap
  );
`endif
endinterface

// File: rtl/stopwatch_time_keeper.sv
// rtl/stopwatch_time_keeper.sv - run/pause/clear FSM keeping elapsed time as BCD MM:SS
// Macro STOPWATCH_LAP_HOLD_EN enables the lap display freeze.
module stopwatch_time_keeper #(
  parameter int MAX_MINUTES = 59,
  parameter bit ROLLOVER    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  stopwatch_time_keeper_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;

  localparam logic [3:0] MAX_M10 = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_M1  = 4'(MAX_MINUTES % 10);

  state_t     state, state_next;
  logic [3:0] s1, s1_n;
  logic [2:0] s10, s10_n;
  logic [3:0] m1, m1_n;
  logic [3:0] m10, m10_n;
  logic       wrap_r, wrap_n;
  logic       running_r, running_n;
  logic       at_limit, count_en;

  assign at_limit = (m10 == MAX_M10) && (m1 == MAX_M1) && (s10 == 3'd5) && (s1 == 4'd9);
  assign count_en = (state == RUN) && bus.tick_in && !bus.clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s1        <= '0;
      s10       <= '0;
      m1        <= '0;
      m10       <= '0;
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state     <= state_next;
      s1        <= s1_n;
      s10       <= s10_n;
      m1        <= m1_n;
      m10       <= m10_n;
      wrap_r    <= wrap_n;
      running_r <= running_n;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_stop) state_next = RUN;
        RUN:     if (bus.start_stop || (count_en && at_limit && !ROLLOVER)) state_next = PAUSED;
        PAUSED:  if (bus.start_stop) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // A tick in RUN is counted even when start_stop pauses in the same cycle.
  always_comb begin
    s1_n      = s1;
    s10_n     = s10;
    m1_n      = m1;
    m10_n     = m10;
    wrap_n    = 1'b0;
    running_n = (state_next == RUN);
    if (bus.clear) begin
      s1_n  = '0;
      s10_n = '0;
      m1_n  = '0;
      m10_n = '0;
    end else if (count_en) begin
      if (at_limit) begin
        wrap_n = 1'b1;
        if (ROLLOVER) begin
          s1_n  = '0;
          s10_n = '0;
          m1_n  = '0;
          m10_n = '0;
        end
      end else if (s1 != 4'd9) begin
        s1_n = s1 + 4'd1;
      end else begin
        s1_n = '0;
        if (s10 != 3'd5) begin
          s10_n = s10 + 3'd1;
        end else begin
          s10_n = '0;
          if (m1 != 4'd9) begin
            m1_n = m1 + 4'd1;
          end else begin
            m1_n  = '0;
            m10_n = (m10 == 4'd9) ? 4'd0 : m10 + 4'd1;
          end
        end
      end
    end
  end

  assign bus.running = running_r;
  assign bus.wrap    = wrap_r;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap_r, lap_n;
  logic [3:0] d_s1, d_m1, d_m10;
  logic [2:0] d_s10;

  always_comb begin
    lap_n = lap_r;
    if (bus.clear)
      lap_n = 1'b0;
    else if (bus.lap && (state != IDLE))
      lap_n = ~lap_r;
  end

  // Display regs track live time while unlatched, so holding them on 0->1 is the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_r <= 1'b0;
      d_s1  <= '0;
      d_s10 <= '0;
      d_m1  <= '0;
      d_m10 <= '0;
    end else begin
      lap_r <= lap_n;
      if (!lap_n) begin
        d_s1  <= s1_n;
        d_s10 <= s10_n;
        d_m1  <= m1_n;
        d_m10 <= m10_n;
      end
    end
  end

  assign bus.lap_active = lap_r;
  assign bus.sec_ones   = d_s1;
  assign bus.sec_tens   = d_s10;
  assign bus.min_ones   = d_m1;
  assign bus.min_tens   = d_m10;
`else
  assign bus.sec_ones   = s1;
  assign bus.sec_tens   = s10;
  assign bus.min_ones   = m1;
  assign bus.min_tens   = m10;
`endif
endmodule

// File: tb/tb_stopwatch_time_keeper.sv
// tb/tb_stopwatch_time_keeper.sv - vector table, corner sequences and random run vs seconds-count model
// Three instances: 59 min wrap, 2 min wrap, 2 min saturate. Honours STOPWATCH_LAP_HOLD_EN.
module tb_stopwatch_time_keeper;
  logic clk = 1'b0;
  logic rst;
  logic tick, ss, clr, lap;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stopwatch_time_keeper_if bus0 ();
  stopwatch_time_keeper_if bus1 ();
  stopwatch_time_keeper_if bus2 ();

  assign bus0.tick_in = tick;  assign bus0.start_stop = ss;  assign bus0.clear = clr;
  assign bus1.tick_in = tick;  assign bus1.start_stop = ss;  assign bus1.clear = clr;
  assign bus2.tick_in = tick;  assign bus2.start_stop = ss;  assign bus2.clear = clr;

  stopwatch_time_keeper #(.MAX_MINUTES(59), .ROLLOVER(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  stopwatch_time_keeper #(.MAX_MINUTES(2),  .ROLLOVER(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  stopwatch_time_keeper #(.MAX_MINUTES(2),  .ROLLOVER(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [16:0] act [3];
  logic        act_lap [3];
  assign act[0] = {bus0.min_tens, bus0.min_ones, bus0.sec_tens, bus0.sec_ones, bus0.running, bus0.wrap};
  assign act[1] = {bus1.min_tens, bus1.min_ones, bus1.sec_tens, bus1.sec_ones, bus1.running, bus1.wrap};
  assign act[2] = {bus2.min_tens, bus2.min_ones, bus2.sec_tens, bus2.sec_ones, bus2.running, bus2.wrap};
`ifdef STOPWATCH_LAP_HOLD_EN
  assign bus0.lap = lap;  assign bus1.lap = lap;  assign bus2.lap = lap;
  assign act_lap[0] = bus0.lap_active;
  assign act_lap[1] = bus1.lap_active;
  assign act_lap[2] = bus2.lap_active;
`else
  assign act_lap[0] = 1'b0;
  assign act_lap[1] = 1'b0;
  assign act_lap[2] = 1'b0;
`endif

  // Reference model: elapsed time as a plain seconds count; st 0=idle 1=run 2=paused
  int limit [3] = '{59*60+59, 2*60+59, 2*60+59};
  bit roll  [3] = '{1'b1, 1'b1, 1'b0};
  int m_total [3];
  int m_disp  [3];
  int m_st    [3];
  bit m_wrap  [3];
  bit m_lapa  [3];

  function automatic logic [16:0] expv(int t, bit r, bit w);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), r, w};
  endfunction

  task automatic chk(string nm, logic [16:0] a, logic [16:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_total[i] = 0; m_disp[i] = 0; m_st[i] = 0; m_wrap[i] = 0; m_lapa[i] = 0;
    end
  endtask

  task automatic model_step(bit t, bit s, bit c, bit l);
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 0;
      if (c) begin
        m_total[i] = 0; m_st[i] = 0; m_lapa[i] = 0;
      end else begin
        bit hit_hold;
        hit_hold = 0;
`ifdef STOPWATCH_LAP_HOLD_EN
        if (l && m_st[i] != 0) m_lapa[i] = !m_lapa[i];
`endif
        if (m_st[i] == 1 && t) begin
          if (m_total[i] == limit[i]) begin
            m_wrap[i] = 1;
            if (roll[i]) m_total[i] = 0;
            else hit_hold = 1;
          end else begin
            m_total[i] = m_total[i] + 1;
          end
        end
        if (m_st[i] == 1) begin
          if (s || hit_hold) m_st[i] = 2;
        end else if (s) begin
          m_st[i] = 1;
        end
      end
      if (!m_lapa[i]) m_disp[i] = m_total[i];
    end
  endtask

  task automatic cyc(bit t, bit s, bit c, bit l);
    tick = t; ss = s; clr = c; lap = l;
    @(posedge clk);
    model_step(t, s, c, l);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_dut%0d", i), act[i], expv(m_disp[i], m_st[i] == 1, m_wrap[i]));
`ifdef STOPWATCH_LAP_HOLD_EN
      chk($sformatf("model_lap_dut%0d", i), {16'b0, act_lap[i]}, {16'b0, m_lapa[i]});
`endif
    end
    tick = 0; ss = 0; clr = 0; lap = 0;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit t, s, c;
    int secs;
    bit run, wr;
  } vec_t;
  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};

    rst = 1'b1; tick = 0; ss = 0; clr = 0; lap = 0;
    model_reset();
    #3;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_dut%0d", i), act[i], expv(0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].t, tbl[i].s, tbl[i].c, 1'b0);
      chk($sformatf("tbl%0d", i), act[0], expv(tbl[i].secs, tbl[i].run, tbl[i].wr));
    end

    // async reset mid-run at 00:37
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(37);
    chk("at_0037", act[0], expv(37, 1, 0));
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("async_rst_dut%0d", i), act[i], expv(0, 0, 0));
    #1 rst = 1'b0;
    model_reset();

    // 75 ticks then pause with ignored ticks
    cyc(0, 1, 0, 0); ticks(75);
    chk("run_0115", act[0], expv(75, 1, 0));
    cyc(0, 1, 0, 0); ticks(10);
    chk("paused_0115", act[0], expv(75, 0, 0));

    // 2-minute limit: wrap vs saturate
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(179);
    chk("pre_limit_dut1", act[1], expv(179, 1, 0));
    ticks(1);
    chk("rollover_dut1", act[1], expv(0, 1, 1));
    chk("saturate_dut2", act[2], expv(179, 0, 1));
    cyc(0, 0, 0, 0);
    chk("wrap_drop_dut1", act[1], expv(0, 1, 0));
    chk("wrap_drop_dut2", act[2], expv(179, 0, 0));
    cyc(0, 1, 0, 0); ticks(1);
    chk("rewrap_dut2", act[2], expv(179, 0, 1));

    // simultaneous events at 00:09
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(9);
    cyc(1, 1, 0, 0);
    chk("tick_ss_run", act[0], expv(10, 0, 0));
    cyc(1, 0, 1, 0);
    chk("tick_clear", act[0], expv(0, 0, 0));

    // carry chain to 10:00, then the 59:59 rollover of the default instance
    cyc(0, 1, 0, 0); ticks(599);
    chk("at_0959", act[0], expv(599, 1, 0));
    ticks(1);
    chk("carry_1000", act[0], expv(600, 1, 0));
    ticks(2999);
    chk("at_5959", act[0], expv(3599, 1, 0));
    ticks(1);
    chk("wrap_5959", act[0], expv(0, 1, 1));

`ifdef STOPWATCH_LAP_HOLD_EN
    cyc(0, 0, 1, 0); cyc(0, 1, 0, 0); ticks(20);
    cyc(0, 0, 0, 1); ticks(5);
    chk("lap_frozen", act[0], expv(20, 1, 0));
    chk("lap_on", {16'b0, act_lap[0]}, 17'd1);
    cyc(0, 0, 0, 1);
    chk("lap_release", act[0], expv(25, 1, 0));
    chk("lap_off", {16'b0, act_lap[0]}, 17'd0);
    cyc(0, 0, 0, 1); ticks(3);
    cyc(1, 0, 1, 1);
    chk("lap_clear", act[0], expv(0, 0, 0));
    chk("lap_clear_flag", {16'b0, act_lap[0]}, 17'd0);
`endif

    cyc(0, 0, 1, 0);
    for (int k = 0; k < 1500; k++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
